// File: rtl/mips_pipeline_pkg.sv
// mips_pipeline_pkg: opcodes, funct codes, ALU ops, size codes and decoded control shared by the MIPS core
package mips_pipeline_pkg;
  localparam int REG_W = 5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A;
  localparam logic [2:0] SZ_BYTE = 3'd0, SZ_HALF = 3'd1, SZ_WORD = 3'd2;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_LUI
  } alu_op_e;
  typedef struct packed {
    alu_op_e alu_op;
    logic imm_src;
    logic reg_write;
    logic [REG_W-1:0] dest;
    logic mem_read;
    logic mem_write;
    logic beq;
    logic bne;
    logic jump;
    logic halt;
  } ctrl_t;
endpackage

// File: rtl/mips_pipeline_alu.sv
// mips_alu: combinational ALU (operands a/b, op -> result, zero flag)
module mips_alu
  import mips_pipeline_pkg::*;
#(
  parameter int NB = 32
) (
  input logic [NB-1:0] a,
  input logic [NB-1:0] b,
  input alu_op_e op,
  output logic [NB-1:0] result,
  output logic zero
);
  assign result = op == ALU_SUB ? a - b :
                  op == ALU_AND ? a & b :
                  op == ALU_OR  ? a | b :
                  op == ALU_XOR ? a ^ b :
                  op == ALU_NOR ? ~(a | b) :
                  op == ALU_SLT ? {{(NB-1){1'b0}}, $signed(a) < $signed(b)} :
                  op == ALU_LUI ? b << 16 :
                  a + b;
  assign zero = result == '0;
endmodule

// File: rtl/mips_pipeline.sv
// mips_pipeline: 5-stage MIPS32 subset core with debug ports; define MIPS_FORWARDING_EN for EX forwarding, else ID stalls on hazards
module mips_pipeline
  import mips_pipeline_pkg::*;
#(
  parameter int NB = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 16
) (
  input logic i_clk,
  input logic i_reset,
  input logic i_step,
  input logic [4:0] i_debug_mips_register_number,
  input logic [NB-1:0] i_debug_address,
  input logic i_instruction_write_enable,
  input logic [NB-1:0] i_instruction_data,
  output logic [NB-1:0] o_mips_pc,
  output logic [NB-1:0] o_mips_alu_result,
  output logic [NB-1:0] o_mips_register_data,
  output logic [NB-1:0] o_mips_data_memory,
  output logic o_mips_wb_halt
);
  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);
  logic [NB-1:0] imem [IMEM_DEPTH];
  logic [NB-1:0] dmem [DMEM_DEPTH];
  logic [NB-1:0] regs [32];
  logic [NB-1:0] pc, ifid_instr, ifid_pc4;
  ctrl_t dec, idex_ctrl;
  logic [NB_SIZE_TYPE-1:0] dec_size, idex_size, exmem_size;
  logic [NB-1:0] idex_a, idex_b, idex_imm, idex_target;
  logic exmem_we, exmem_rd, exmem_wr, exmem_halt, memwb_we, memwb_halt;
  logic [REG_W-1:0] exmem_dest, memwb_dest, rs, rt, rd;
  logic [NB-1:0] exmem_alu, exmem_st, memwb_data;
  logic adv, stall, taken, flush, zext, zero, wb_we;
  logic [5:0] op, fn;
  logic [NB-1:0] imm, target, rs_val, rt_val, fa, fb, alu_b, alu_y;
  logic [NB-1:0] mword, shifted, ld, bmask, mask, st_word, wb_val;
  logic [4:0] sh_amt;
  logic [DA_W-1:0] widx;
  logic unused_bits;
  assign adv = i_step && !memwb_halt;
  assign o_mips_pc = pc;
  assign o_mips_wb_halt = memwb_halt;
  assign o_mips_alu_result = alu_y;
  assign op = ifid_instr[31:26];
  assign rs = ifid_instr[25:21];
  assign rt = ifid_instr[20:16];
  assign rd = ifid_instr[15:11];
  assign fn = ifid_instr[5:0];
  assign wb_we = memwb_we && memwb_dest != '0;
  assign rs_val = (wb_we && memwb_dest == rs) ? memwb_data : regs[rs];
  assign rt_val = (wb_we && memwb_dest == rt) ? memwb_data : regs[rt];
  assign o_mips_register_data = (wb_we && memwb_dest == i_debug_mips_register_number) ? memwb_data : regs[i_debug_mips_register_number];
  assign o_mips_data_memory = dmem[i_debug_address[DA_W+1:2]];
  always_comb begin
    dec = '0;
    dec_size = SZ_WORD;
    zext = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec.dest = rd;
        dec.reg_write = fn inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT};
        dec.alu_op = fn == FN_SUBU ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
                     fn == FN_XOR ? ALU_XOR : fn == FN_NOR ? ALU_NOR : fn == FN_SLT ? ALU_SLT : ALU_ADD;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.imm_src = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest = rt;
        zext = op inside {OP_ANDI, OP_ORI, OP_XORI};
        dec.alu_op = op == OP_SLTI ? ALU_SLT : op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR :
                     op == OP_XORI ? ALU_XOR : op == OP_LUI ? ALU_LUI : ALU_ADD;
      end
      OP_LB, OP_LH, OP_LW: begin
        dec.imm_src = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest = rt;
        dec.mem_read = 1'b1;
        dec_size = op == OP_LB ? SZ_BYTE : op == OP_LH ? SZ_HALF : SZ_WORD;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec.imm_src = 1'b1;
        dec.mem_write = 1'b1;
        dec_size = op == OP_SB ? SZ_BYTE : op == OP_SH ? SZ_HALF : SZ_WORD;
      end
      OP_BEQ: begin
        dec.alu_op = ALU_SUB;
        dec.beq = 1'b1;
      end
      OP_BNE: begin
        dec.alu_op = ALU_SUB;
        dec.bne = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      default: ;
    endcase
    dec.halt = ifid_instr == HALT_WORD;
  end
  assign imm = zext ? {{(NB-16){1'b0}}, ifid_instr[15:0]} : {{(NB-16){ifid_instr[15]}}, ifid_instr[15:0]};
  assign target = dec.jump ? {ifid_pc4[NB-1:NB-4], ifid_instr[25:0], 2'b00} : ifid_pc4 + (imm << 2);
`ifdef MIPS_FORWARDING_EN
  logic [REG_W-1:0] idex_rs, idex_rt;
  assign stall = idex_ctrl.mem_read && idex_ctrl.dest != '0 && (idex_ctrl.dest == rs || idex_ctrl.dest == rt);
  assign fa = (exmem_we && exmem_dest != '0 && exmem_dest == idex_rs) ? exmem_alu :
              (wb_we && memwb_dest == idex_rs) ? memwb_data : idex_a;
  assign fb = (exmem_we && exmem_dest != '0 && exmem_dest == idex_rt) ? exmem_alu :
              (wb_we && memwb_dest == idex_rt) ? memwb_data : idex_b;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex_rs <= '0;
      idex_rt <= '0;
    end else if (adv) begin
      idex_rs <= flush ? '0 : rs;
      idex_rt <= flush ? '0 : rt;
    end
  end
`else
  assign stall = (idex_ctrl.reg_write && idex_ctrl.dest != '0 && (idex_ctrl.dest == rs || idex_ctrl.dest == rt)) ||
                 (exmem_we && exmem_dest != '0 && (exmem_dest == rs || exmem_dest == rt));
  assign fa = idex_a;
  assign fb = idex_b;
`endif
  assign alu_b = idex_ctrl.imm_src ? idex_imm : fb;
  mips_alu #(.NB(NB)) u_alu (.a(fa), .b(alu_b), .op(idex_ctrl.alu_op), .result(alu_y), .zero(zero));
  assign taken = idex_ctrl.jump || (idex_ctrl.beq && zero) || (idex_ctrl.bne && !zero);
  assign flush = taken || stall;
  assign widx = exmem_alu[DA_W+1:2];
  assign mword = dmem[widx];
  assign sh_amt = {exmem_alu[1:0], 3'b000};
  assign shifted = mword >> sh_amt;
  assign ld = exmem_size == SZ_BYTE ? {{(NB-8){shifted[7]}}, shifted[7:0]} :
              exmem_size == SZ_HALF ? {{(NB-16){shifted[15]}}, shifted[15:0]} : mword;
  assign bmask = exmem_size == SZ_BYTE ? {{(NB-8){1'b0}}, 8'hFF} :
                 exmem_size == SZ_HALF ? {{(NB-16){1'b0}}, 16'hFFFF} : '1;
  assign mask = bmask << sh_amt;
  assign st_word = (mword & ~mask) | ((exmem_st << sh_amt) & mask);
  assign wb_val = exmem_rd ? ld : exmem_alu;
  assign unused_bits = ^{i_debug_address[1:0], i_debug_address[NB-1:IA_W+2], shifted[NB-1:16]};
  always_ff @(posedge i_clk) begin
    if (i_instruction_write_enable && !i_step) imem[i_debug_address[IA_W+1:2]] <= i_instruction_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc <= '0;
      ifid_instr <= NOP_WORD;
      ifid_pc4 <= '0;
      idex_ctrl <= '0;
      idex_size <= '0;
      idex_a <= '0;
      idex_b <= '0;
      idex_imm <= '0;
      idex_target <= '0;
      exmem_we <= 1'b0;
      exmem_rd <= 1'b0;
      exmem_wr <= 1'b0;
      exmem_halt <= 1'b0;
      exmem_dest <= '0;
      exmem_size <= '0;
      exmem_alu <= '0;
      exmem_st <= '0;
      memwb_we <= 1'b0;
      memwb_halt <= 1'b0;
      memwb_dest <= '0;
      memwb_data <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (adv) begin
      pc <= taken ? idex_target : stall ? pc : pc + NB'(4);
      if (!stall || taken) begin
        ifid_instr <= taken ? NOP_WORD : imem[pc[IA_W+1:2]];
        ifid_pc4 <= pc + NB'(4);
      end
      idex_ctrl <= flush ? '0 : dec;
      idex_size <= flush ? '0 : dec_size;
      idex_a <= flush ? '0 : rs_val;
      idex_b <= flush ? '0 : rt_val;
      idex_imm <= flush ? '0 : imm;
      idex_target <= flush ? '0 : target;
      exmem_we <= idex_ctrl.reg_write;
      exmem_rd <= idex_ctrl.mem_read;
      exmem_wr <= idex_ctrl.mem_write;
      exmem_halt <= idex_ctrl.halt;
      exmem_dest <= idex_ctrl.dest;
      exmem_size <= idex_size;
      exmem_alu <= alu_y;
      exmem_st <= fb;
      memwb_we <= exmem_we;
      memwb_halt <= exmem_halt;
      memwb_dest <= exmem_dest;
      memwb_data <= wb_val;
      if (wb_we) regs[memwb_dest] <= memwb_data;
      if (exmem_wr) dmem[widx] <= st_word;
    end
  end
endmodule

// File: tb/tb_mips_pipeline.sv
// tb_mips_pipeline: scoreboard bench for mips_pipeline (PC sequence, branches, forwarding/stall, memory, halt)
module tb_mips_pipeline;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_step = 1'b0;
  logic [4:0] i_debug_mips_register_number = '0;
  logic [31:0] i_debug_address = '0;
  logic i_instruction_write_enable = 1'b0;
  logic [31:0] i_instruction_data = '0;
  logic [31:0] o_mips_pc, o_mips_alu_result, o_mips_register_data, o_mips_data_memory;
  logic o_mips_wb_halt;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  mips_pipeline dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_step(i_step),
    .i_debug_mips_register_number(i_debug_mips_register_number),
    .i_debug_address(i_debug_address),
    .i_instruction_write_enable(i_instruction_write_enable),
    .i_instruction_data(i_instruction_data),
    .o_mips_pc(o_mips_pc),
    .o_mips_alu_result(o_mips_alu_result),
    .o_mips_register_data(o_mips_register_data),
    .o_mips_data_memory(o_mips_data_memory),
    .o_mips_wb_halt(o_mips_wb_halt)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic load(input int a, input logic [31:0] w);
    i_step = 1'b0;
    i_debug_address = a;
    i_instruction_data = w;
    i_instruction_write_enable = 1'b1;
    tick;
    i_instruction_write_enable = 1'b0;
  endtask
  task automatic clear_imem;
    for (int a = 0; a < 64; a++) load(a * 4, 32'h0);
  endtask
  task automatic do_reset;
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
  endtask
  task automatic run(input int n, input string tag);
    i_step = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick;
      if (exp_q.size() > 0) check(tag, o_mips_pc, exp_q.pop_front());
    end
    i_step = 1'b0;
  endtask
  task automatic reg_is(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    i_debug_mips_register_number = idx;
    #1;
    check(tag, o_mips_register_data, exp);
  endtask
  task automatic mem_is(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    i_debug_address = addr;
    #1;
    check(tag, o_mips_data_memory, exp);
  endtask
  initial begin
    int cyc;
    clear_imem;
    do_reset;
    check("rst_pc", o_mips_pc, 32'd0);
    check("rst_halt", {31'd0, o_mips_wb_halt}, 32'd0);
    reg_is(5'd5, 32'd0, "rst_reg5");
    for (int k = 1; k <= 7; k++) exp_q.push_back(k * 4);
    run(7, "nop_pc");
    tick;
    tick;
    check("hold_pc", o_mips_pc, 32'd28);
    check("nop_alu", o_mips_alu_result, 32'd0);
    load(0, itype(6'h08, 5'd0, 5'd4, 16'd7));
    load(4, itype(6'h08, 5'd0, 5'd8, 16'd7));
    load(20, itype(6'h04, 5'd4, 5'd8, 16'd3));
    load(24, itype(6'h08, 5'd0, 5'd9, 16'd1));
    load(28, itype(6'h08, 5'd0, 5'd10, 16'd1));
    do_reset;
    for (int k = 1; k <= 7; k++) exp_q.push_back(k * 4);
    run(7, "beq_pc");
    check("beq_alu", o_mips_alu_result, 32'd0);
    exp_q.push_back(32'd36);
    run(1, "beq_target");
    run(5, "beq_drain");
    reg_is(5'd4, 32'd7, "beq_r4");
    reg_is(5'd8, 32'd7, "beq_r8");
    reg_is(5'd9, 32'd0, "beq_flush_r9");
    reg_is(5'd10, 32'd0, "beq_flush_r10");
    load(4, itype(6'h08, 5'd0, 5'd8, 16'd5));
    load(20, itype(6'h05, 5'd4, 5'd8, 16'hFFFA));
    do_reset;
    for (int k = 1; k <= 7; k++) exp_q.push_back(k * 4);
    run(7, "bne_pc");
    check("bne_alu", o_mips_alu_result, 32'd2);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    run(3, "bne_target");
    run(4, "bne_drain");
    reg_is(5'd8, 32'd5, "bne_r8");
    reg_is(5'd9, 32'd0, "bne_flush_r9");
    reg_is(5'd10, 32'd0, "bne_flush_r10");
    clear_imem;
    load(0, itype(6'h08, 5'd0, 5'd1, 16'd5));
    load(4, rtype(5'd1, 5'd1, 5'd2, 6'h21));
    load(8, itype(6'h2B, 5'd0, 5'd2, 16'd8));
    load(12, itype(6'h23, 5'd0, 5'd3, 16'd8));
    load(16, rtype(5'd3, 5'd3, 5'd4, 6'h21));
    load(20, itype(6'h28, 5'd0, 5'd1, 16'd70));
    load(24, itype(6'h21, 5'd0, 5'd6, 16'd6));
    load(28, itype(6'h08, 5'd0, 5'd7, 16'hFF80));
    load(32, itype(6'h28, 5'd0, 5'd7, 16'd3));
    load(36, itype(6'h20, 5'd0, 5'd9, 16'd3));
    do_reset;
`ifdef MIPS_FORWARDING_EN
    foreach (exp_q[k]) exp_q.delete(k);
    for (int k = 0; k < 12; k++) exp_q.push_back(k < 5 ? (k + 1) * 4 : k * 4);
`else
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd16);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd24);
`endif
    run(12, "hazard_pc");
    run(24, "mem_drain");
    reg_is(5'd1, 32'd5, "fwd_r1");
    reg_is(5'd2, 32'd10, "fwd_r2");
    reg_is(5'd3, 32'd10, "lw_r3");
    reg_is(5'd4, 32'd20, "loaduse_r4");
    reg_is(5'd6, 32'd5, "lh_r6");
    reg_is(5'd7, 32'hFFFF_FF80, "addi_neg_r7");
    reg_is(5'd9, 32'hFFFF_FF80, "lb_sext_r9");
    mem_is(32'd8, 32'd10, "sw_mem8");
    mem_is(32'd72, 32'd10, "wrap_mem72");
    mem_is(32'd4, 32'h0005_0000, "sb_wrap_mem4");
    mem_is(32'd0, 32'h8000_0000, "sb_fwd_mem0");
    clear_imem;
    load(0, itype(6'h08, 5'd0, 5'd5, 16'd1));
    load(4, 32'hFFFF_FFFF);
    load(8, itype(6'h08, 5'd0, 5'd6, 16'd9));
    do_reset;
    cyc = 0;
    i_step = 1'b1;
    while (!o_mips_wb_halt && cyc < 20) begin
      tick;
      cyc++;
    end
    i_step = 1'b0;
    check("halt_seen", {31'd0, o_mips_wb_halt}, 32'd1);
    check("halt_steps", cyc, 32'd5);
    check("halt_pc", o_mips_pc, 32'd20);
    run(3, "halt_frozen");
    check("halt_pc_frozen", o_mips_pc, 32'd20);
    reg_is(5'd5, 32'd1, "halt_r5");
    reg_is(5'd6, 32'd0, "halt_r6_ignored");
    do_reset;
    check("halt_clear", {31'd0, o_mips_wb_halt}, 32'd0);
    check("halt_rst_pc", o_mips_pc, 32'd0);
    reg_is(5'd5, 32'd0, "halt_rst_r5");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_pipeline.md
Name: mips_pipeline

Overview:
- Classic 5-stage MIPS32 integer pipeline (IF, ID, EX, MEM, WB) with internal instruction and data memories.
- Top-level core of the debug SoC. The debug unit steps it with i_step and inspects PC, the EX ALU result, registers and data memory through combinational debug ports.
- Implements a reduced subset with forwarding, load-use stall and branch flush.

Parameters:
- NB, 32, datapath/word width.
- NB_SIZE_TYPE, 3, width of the load/store size code carried in pipeline registers (byte=0, half=1, word=2).
- IMEM_DEPTH, 64, instruction memory depth in words.
- DMEM_DEPTH, 16, data memory depth in words.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_step  in  1  pipeline advance enable, sampled every rising edge.
- i_debug_mips_register_number  in  5  register index for o_mips_register_data.
- i_debug_address  in  NB  byte address for debug data-memory read and instruction load.
- i_instruction_write_enable  in  1  writes i_instruction_data to imem[i_debug_address>>2].
- i_instruction_data  in  NB  instruction word to load.
- o_mips_pc  out  NB  current PC register (IF stage address).
- o_mips_alu_result  out  NB  combinational ALU output of the instruction currently in EX.
- o_mips_register_data  out  NB  regfile[i_debug_mips_register_number], combinational.
- o_mips_data_memory  out  NB  dmem word at i_debug_address[..:2], combinational.
- o_mips_wb_halt  out  1  HALT has reached WB.

Behaviour:
- Reset (i_reset=1 at an edge):
  - PC=0.
  - All pipeline registers become NOP (0x00000000, no writes).
  - Register file and data memory cleared to 0.
  - o_mips_wb_halt=0.
  - Instruction memory retained.
- State update occurs only at edges with i_step=1 and i_reset=0 and o_mips_wb_halt=0. Otherwise everything holds.
- Instruction loading works only while not stepping.
- PC advances by 4 per step. The sequence after reset is 4, 8, 12, ...
- Instruction fetched at PC reaches EX two steps later.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT. Encoding 0x00000000 is NOP.
  - Immediate: ADDI/ADDIU (sign-extended), ANDI/ORI/XORI (zero-extended), SLTI, LUI.
  - Memory: LB, LH, LW (sign-extending), SB, SH, SW.
  - Control: BEQ, BNE, J.
  - HALT = 0xFFFFFFFF.
  - Unknown opcodes behave as NOP.
- BEQ/BNE:
  - ALU computes rs-rt in EX, so o_mips_alu_result = rs-rt while the branch is in EX.
  - Target = branch PC + 4 + (sign_extend(offset) << 2).
  - Taken decision is made in EX. At the edge where the branch moves EX->MEM, PC loads the target, and the IF/ID and ID/EX instructions become NOPs.
  - Not-taken branches continue sequentially.
- J: target = {PC+4[31:28], index, 2'b00}. Resolved the same way in EX, with the same 2-instruction flush.
- Forwarding:
  - EX operands are taken from EX/MEM first, then MEM/WB, then ID/EX.
  - Register $0 always reads 0 and is never forwarded.
- Register file is write-first: a WB write is visible to the ID read and to the debug port in the same cycle.
- Load-use: if the EX instruction is a load whose rt matches the ID rs/rt, PC and IF/ID hold for one step and a bubble is inserted into EX.
- Data memory:
  - Byte addressed, little-endian lanes.
  - Word index is addr[log2(DMEM_DEPTH)+1:2], so addresses wrap modulo the memory size.
  - Write occurs in MEM on the step edge.
- HALT:
  - Flows through as a NOP. Instructions fetched after it are ignored once it commits.
  - When it reaches WB, o_mips_wb_halt=1, and the pipeline and PC freeze until reset.
  - Older instructions complete before HALT reaches WB.
- Simultaneous branch-taken and load-use stall: the branch wins (flush, PC=target).

Optional Feature:
- MIPS_FORWARDING_EN
  - Defined: the forwarding paths above are present.
  - Undefined: no forwarding paths. ID stalls while any instruction in EX or MEM writes a nonzero register matching the ID sources. Architectural results are identical; only PC timing differs.

Decomposition:
- Shared package/header holds:
  - opcode and funct codes, HALT and NOP words;
  - ALU operation codes;
  - size codes;
  - pipeline-register field widths.
- One natural sub-module: mips_alu (operands, op code -> result, zero flag).
- Hazard/forward logic, regfile and memories stay inline.

Test Plan:
- Reset, then i_step=1 with NOP program -> o_mips_pc reads 4, 8, ..., 28 on successive edges. i_step=0 -> PC holds.
- ADDI $4,$0,7 ; ADDI $8,$0,7 ; NOPs ; BEQ $4,$8,1 at address 20 -> at PC=28 o_mips_alu_result=0. Next PC=28+? target 28 (branch taken). With offset 3 -> next PC=36, and the two wrong-path instructions do not write registers.
- Same program with $8=5, BNE $4,$8,-6 at address 20 -> o_mips_alu_result=2 in EX, next PC=0.
- ADDI $1,$0,5 ; ADDU $2,$1,$1 back-to-back -> $2 reads 10 via debug port after writeback.
- SW $2,8($0) ; LW $3,8($0) ; ADDU $4,$3,$3 -> one stall cycle (PC held once). $4=20 and o_mips_data_memory at address 8 reads 10.
- HALT after ADDI $5,$0,1 -> o_mips_wb_halt=1, $5=1, PC frozen despite i_step=1. Reset clears it.
